// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, a registered fetch-side
// decode stage, and pixel-side sync/blank outputs delayed through a shift register.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CNT_W     = 11,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PIPE_DLY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_scale,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             fetch_en,
    output logic [CNT_W-1:0] fetch_x,
    output logic [CNT_W-1:0] fetch_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             de_o,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             vblank_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             started;
    logic [1:0]       scale_pend;
    logic [1:0]       scale_act;
    logic [1:0]       shamt;
    logic             live;
    logic             fetch_en_d;
    logic [CNT_W-1:0] fetch_x_d;
    logic [CNT_W-1:0] fetch_y_d;
    logic             line_start_d;
    logic             frame_start_d;
    logic [3:0]       pix_d;
    // pixel-side flags {de, hsync asserted, vsync asserted, vblank}; index 0 is stage 0
    logic [3:0]       pix_q [0:PIPE_DLY];

    // started holds the counters at (0,0) for the first enabled edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            started <= 1'b0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            started <= 1'b1;
            if (started) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_pend <= '0;
            scale_act  <= '0;
        end else begin
            if (cfg_wr)
                scale_pend <= cfg_scale;
            if (h_cnt == '0 && v_cnt == '0)
                scale_act <= scale_pend;
        end
    end

    always_comb begin
        shamt         = 2'd0;
        live          = en & started;
        fetch_en_d    = 1'b0;
        fetch_x_d     = '0;
        fetch_y_d     = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        pix_d         = '0;
        case (scale_act)
            2'd0:    shamt = 2'd0;
            2'd1:    shamt = 2'd1;
            default: shamt = 2'd2;
        endcase
        if (live) begin
            fetch_en_d    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (fetch_en_d) begin
                fetch_x_d = h_cnt >> shamt;
                fetch_y_d = v_cnt >> shamt;
            end
            pix_d = {fetch_en_d,
                     (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END),
                     (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END),
                     (v_cnt >= V_ACT_END)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int unsigned i = 0; i <= PIPE_DLY; i++)
                pix_q[i] <= '0;
        end else begin
            fetch_en    <= fetch_en_d;
            fetch_x     <= fetch_x_d;
            fetch_y     <= fetch_y_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
            pix_q[0]    <= pix_d;
            for (int unsigned i = 1; i <= PIPE_DLY; i++)
                pix_q[i] <= pix_q[i-1];
        end
    end

    always_comb begin
        de_o     = pix_q[PIPE_DLY][3];
        h_sync_o = pix_q[PIPE_DLY][2] ? HSYNC_POL : ~HSYNC_POL;
        v_sync_o = pix_q[PIPE_DLY][1] ? VSYNC_POL : ~VSYNC_POL;
        vblank_o = pix_q[PIPE_DLY][0];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a reduced-timing instance for frame-level checks,
// a default instance for line timing, and a tiny HSYNC_POL=1 / PIPE_DLY=0 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n, en, cfg_wr;
    logic [1:0] cfg_scale;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [10:0] s_h_cnt, s_v_cnt, s_fetch_x, s_fetch_y;
    logic s_fetch_en, s_line_start, s_frame_start, s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o;
    logic [10:0] d_h_cnt, d_v_cnt, d_fetch_x, d_fetch_y;
    logic d_fetch_en, d_line_start, d_frame_start, d_de_o, d_h_sync_o, d_v_sync_o, d_vblank_o;
    logic [10:0] p_h_cnt, p_v_cnt, p_fetch_x, p_fetch_y;
    logic p_fetch_en, p_line_start, p_frame_start, p_de_o, p_h_sync_o, p_v_sync_o, p_vblank_o;

    // reduced raster: 80 clks/line (sync h 68..75), 56 lines/frame (sync v 50..51)
    vga_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                     .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
                     .CNT_W(11), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DLY(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_scale(cfg_scale),
        .h_cnt(s_h_cnt), .v_cnt(s_v_cnt), .fetch_en(s_fetch_en), .fetch_x(s_fetch_x),
        .fetch_y(s_fetch_y), .line_start(s_line_start), .frame_start(s_frame_start),
        .de_o(s_de_o), .h_sync_o(s_h_sync_o), .v_sync_o(s_v_sync_o), .vblank_o(s_vblank_o));

    vga_timing_gen dut_def (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_scale(cfg_scale),
        .h_cnt(d_h_cnt), .v_cnt(d_v_cnt), .fetch_en(d_fetch_en), .fetch_x(d_fetch_x),
        .fetch_y(d_fetch_y), .line_start(d_line_start), .frame_start(d_frame_start),
        .de_o(d_de_o), .h_sync_o(d_h_sync_o), .v_sync_o(d_v_sync_o), .vblank_o(d_vblank_o));

    // tiny raster: 16 clks/line, sync h 10..12
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
                     .HSYNC_POL(1'b1), .PIPE_DLY(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_scale(cfg_scale),
        .h_cnt(p_h_cnt), .v_cnt(p_v_cnt), .fetch_en(p_fetch_en), .fetch_x(p_fetch_x),
        .fetch_y(p_fetch_y), .line_start(p_line_start), .frame_start(p_frame_start),
        .de_o(p_de_o), .h_sync_o(p_h_sync_o), .v_sync_o(p_v_sync_o), .vblank_o(p_vblank_o));

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; cfg_wr = 1'b0; cfg_scale = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if ({s_h_cnt, s_v_cnt} !== 22'd0) begin failures++;
            $display("FAIL rst_cnt actual=%h expected=0", {s_h_cnt, s_v_cnt}); end
        checks++; if ({s_fetch_en, s_fetch_x, s_fetch_y, s_line_start, s_frame_start} !== 25'd0) begin failures++;
            $display("FAIL rst_fetch actual=%h expected=0", {s_fetch_en, s_fetch_x, s_fetch_y, s_line_start, s_frame_start}); end
        checks++; if ({s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o} !== 4'b0110) begin failures++;
            $display("FAIL rst_pix actual=%b expected=0110", {s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o}); end
        checks++; if ({p_h_sync_o, p_v_sync_o} !== 2'b01) begin failures++;
            $display("FAIL rst_pol actual=%b expected=01", {p_h_sync_o, p_v_sync_o}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({s_h_cnt, s_frame_start, s_line_start} !== 13'd0) begin failures++;
            $display("FAIL first_hold actual=%h expected=0", {s_h_cnt, s_frame_start, s_line_start}); end
        @(negedge clk);
        checks++; if ({s_h_cnt, s_frame_start, s_line_start, s_fetch_en} !== {11'd1, 3'b111}) begin failures++;
            $display("FAIL first_count actual=%h expected=%h", {s_h_cnt, s_frame_start, s_line_start, s_fetch_en}, {11'd1, 3'b111}); end
        @(negedge clk);
        checks++; if ({s_h_cnt, s_frame_start, s_fetch_x} !== {11'd2, 1'b0, 11'd1}) begin failures++;
            $display("FAIL second_count actual=%h expected=%h", {s_h_cnt, s_frame_start, s_fetch_x}, {11'd2, 1'b0, 11'd1}); end
    endtask

    task automatic test_default_line();
        int n = 0;
        bit found = 0;
        bit fe_p, de_p, hs_p;
        int de_r = -1, de_f = -1, hs_f = -1, hs_r = -1, fe_r = -1, hs_lo = 0;
        fe_p = d_fetch_en;
        while (!found && n < 2000) begin
            @(negedge clk); n++;
            found = d_fetch_en && !fe_p;
            fe_p = d_fetch_en;
        end
        checks++; if (!found) begin failures++;
            $display("FAIL def_wait actual=timeout expected=fetch_en rise"); end
        checks++; if (d_line_start !== 1'b1) begin failures++;
            $display("FAIL def_line_start actual=%b expected=1", d_line_start); end
        de_p = d_de_o; hs_p = d_h_sync_o; fe_p = 1'b1;
        for (int t = 1; t <= 800; t++) begin
            @(negedge clk);
            if (d_de_o && !de_p && de_r < 0) de_r = t;
            if (!d_de_o && de_p && de_f < 0) de_f = t;
            if (!d_h_sync_o && hs_p && hs_f < 0) hs_f = t;
            if (d_h_sync_o && !hs_p && hs_r < 0) hs_r = t;
            if (d_fetch_en && !fe_p && fe_r < 0) fe_r = t;
            if (t < 800 && !d_h_sync_o) hs_lo++;
            de_p = d_de_o; hs_p = d_h_sync_o; fe_p = d_fetch_en;
        end
        checks++; if (de_r != 2) begin failures++; $display("FAIL def_de_rise actual=%0d expected=2", de_r); end
        checks++; if (de_f != 642) begin failures++; $display("FAIL def_de_fall actual=%0d expected=642", de_f); end
        checks++; if (hs_f != 658) begin failures++; $display("FAIL def_hs_fall actual=%0d expected=658", hs_f); end
        checks++; if (hs_r != 754) begin failures++; $display("FAIL def_hs_rise actual=%0d expected=754", hs_r); end
        checks++; if (hs_lo != 96) begin failures++; $display("FAIL def_hs_width actual=%0d expected=96", hs_lo); end
        checks++; if (fe_r != 800) begin failures++; $display("FAIL def_h_period actual=%0d expected=800", fe_r); end
    endtask

    task automatic test_frame();
        int n = 0;
        bit found = 0;
        bit vb_p, vs_p;
        int vb_r = -1, vs_f = -1, de_n = 0, vb_n = 0, vs_n = 0, ls_n = 0, fs_n = 0, max_h = 0, max_v = 0;
        while (!found && n < 5000) begin
            @(negedge clk); n++;
            found = (s_frame_start === 1'b1);
        end
        checks++; if (!found) begin failures++;
            $display("FAIL frame_wait actual=timeout expected=frame_start"); end
        vb_p = s_vblank_o; vs_p = s_v_sync_o;
        for (int t = 0; t <= 4480; t++) begin
            if (t > 0) @(negedge clk);
            if (t < 4480) begin
                de_n += s_de_o ? 1 : 0;
                vb_n += s_vblank_o ? 1 : 0;
                vs_n += s_v_sync_o ? 0 : 1;
                ls_n += s_line_start ? 1 : 0;
                if (t > 0) fs_n += s_frame_start ? 1 : 0;
                if (int'(s_h_cnt) > max_h) max_h = int'(s_h_cnt);
                if (int'(s_v_cnt) > max_v) max_v = int'(s_v_cnt);
                if (s_vblank_o && !vb_p && vb_r < 0) vb_r = t;
                if (!s_v_sync_o && vs_p && vs_f < 0) vs_f = t;
            end
            vb_p = s_vblank_o; vs_p = s_v_sync_o;
        end
        checks++; if (s_frame_start !== 1'b1) begin failures++;
            $display("FAIL frame_period actual=%b expected=1 at 4480", s_frame_start); end
        checks++; if (de_n != 3072) begin failures++; $display("FAIL frame_de_count actual=%0d expected=3072", de_n); end
        checks++; if (vb_n != 640) begin failures++; $display("FAIL frame_vblank_count actual=%0d expected=640", vb_n); end
        checks++; if (vb_r != 3842) begin failures++; $display("FAIL frame_vblank_rise actual=%0d expected=3842", vb_r); end
        checks++; if (vs_n != 160) begin failures++; $display("FAIL frame_vs_width actual=%0d expected=160", vs_n); end
        checks++; if (vs_f != 4002) begin failures++; $display("FAIL frame_vs_fall actual=%0d expected=4002", vs_f); end
        checks++; if (ls_n != 56) begin failures++; $display("FAIL frame_lines actual=%0d expected=56", ls_n); end
        checks++; if (fs_n != 0) begin failures++; $display("FAIL frame_extra_fs actual=%0d expected=0", fs_n); end
        checks++; if (max_h != 79 || max_v != 55) begin failures++;
            $display("FAIL frame_cnt_max actual=%0d,%0d expected=79,55", max_h, max_v); end
    endtask

    // Walks one reduced frame from its frame_start sample (t=0..4478); returns statistics only.
    task automatic scan_frame(input int s, output int mx, output int my, output int bad, output int stray);
        int line = -1, k = 0;
        bit fe_p = 1'b0;
        mx = 0; my = 0; bad = 0; stray = 0;
        for (int t = 0; t < 4479; t++) begin
            if (t > 0) @(negedge clk);
            if (s_fetch_en) begin
                if (!fe_p) begin line++; k = 0; end
                if (s_fetch_x !== 11'(k >> s)) bad++;
                if (s_fetch_y !== 11'(line >> s)) bad++;
                if (int'(s_fetch_x) > mx) mx = int'(s_fetch_x);
                if (int'(s_fetch_y) > my) my = int'(s_fetch_y);
                k++;
            end else if (s_fetch_x !== 11'd0 || s_fetch_y !== 11'd0) begin
                stray++;
            end
            fe_p = s_fetch_en;
        end
    endtask

    task automatic test_scale();
        int n = 0;
        bit found = 0;
        int mx, my, bad, stray, max_a = 0;
        while (!found && n < 5000) begin
            @(negedge clk); n++;
            found = (s_v_cnt == 11'd20);
        end
        checks++; if (!found) begin failures++; $display("FAIL scale_wait actual=timeout expected=v_cnt 20"); end
        cfg_scale = 2'd1; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        found = 0; n = 0;
        while (!found && n < 5000) begin
            if (s_fetch_en && int'(s_fetch_x) > max_a) max_a = int'(s_fetch_x);
            @(negedge clk); n++;
            found = (s_frame_start === 1'b1);
        end
        checks++; if (!found || max_a != 63) begin failures++;
            $display("FAIL scale_mid_frame actual=%0d expected=63", max_a); end
        scan_frame(1, mx, my, bad, stray);
        checks++; if (bad != 0) begin failures++; $display("FAIL scale2x_pattern actual=%0d bad expected=0", bad); end
        checks++; if (mx != 31 || my != 23) begin failures++;
            $display("FAIL scale2x_max actual=%0d,%0d expected=31,23", mx, my); end
        checks++; if (stray != 0) begin failures++; $display("FAIL fetch_idle_zero actual=%0d expected=0", stray); end
        // write on the (0,0) clock must not affect the frame starting there
        @(negedge clk);
        cfg_scale = 2'd3; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        checks++; if (s_frame_start !== 1'b1) begin failures++;
            $display("FAIL scale_fs_align actual=%b expected=1", s_frame_start); end
        scan_frame(1, mx, my, bad, stray);
        checks++; if (bad != 0 || mx != 31) begin failures++;
            $display("FAIL scale_at_origin actual=%0d bad max %0d expected=0 bad max 31", bad, mx); end
        @(negedge clk);
        @(negedge clk);
        scan_frame(2, mx, my, bad, stray);
        checks++; if (bad != 0 || mx != 15 || my != 11) begin failures++;
            $display("FAIL scale_reserved actual=%0d bad max %0d,%0d expected=0 bad max 15,11", bad, mx, my); end
    endtask

    task automatic test_enable();
        int n = 0;
        bit found = 0;
        int bad_cnt = 0, bad_pulse = 0;
        logic de2 = 1'b0, de3 = 1'b1;
        while (!found && n < 5000) begin
            @(negedge clk); n++;
            found = (s_h_cnt == 11'd30 && s_v_cnt == 11'd20);
        end
        checks++; if (!found) begin failures++; $display("FAIL en_wait actual=timeout expected=(30,20)"); end
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (s_h_cnt !== 11'd0 || s_v_cnt !== 11'd0) bad_cnt++;
            if (s_frame_start || s_line_start || s_fetch_en) bad_pulse++;
            if (k == 2) de2 = s_de_o;
            if (k == 3) de3 = s_de_o;
        end
        checks++; if (bad_cnt != 0) begin failures++; $display("FAIL en_cnt_hold actual=%0d bad expected=0", bad_cnt); end
        checks++; if (bad_pulse != 0) begin failures++; $display("FAIL en_stage0_clear actual=%0d bad expected=0", bad_pulse); end
        checks++; if ({de2, de3} !== 2'b10) begin failures++;
            $display("FAIL en_de_drain actual=%b expected=10", {de2, de3}); end
        checks++; if ({s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o, s_fetch_x} !== {4'b0110, 11'd0}) begin failures++;
            $display("FAIL en_pix_idle actual=%h expected=%h", {s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o, s_fetch_x}, {4'b0110, 11'd0}); end
        en = 1'b1;
        @(negedge clk);
        checks++; if ({s_frame_start, s_h_cnt} !== {1'b1, 11'd1}) begin failures++;
            $display("FAIL en_restart actual=%h expected=%h", {s_frame_start, s_h_cnt}, {1'b1, 11'd1}); end
        @(negedge clk);
        checks++; if (s_frame_start !== 1'b0) begin failures++;
            $display("FAIL en_restart_pulse actual=%b expected=0", s_frame_start); end
    endtask

    task automatic test_polarity();
        int n = 0;
        bit found = 0;
        int hs_hi = 0, hs_bad = 0, de_bad = 0;
        while (!found && n < 200) begin
            @(negedge clk); n++;
            found = (p_line_start === 1'b1 && p_fetch_en === 1'b1);
        end
        checks++; if (!found) begin failures++; $display("FAIL pol_wait actual=timeout expected=active line_start"); end
        for (int t = 0; t < 16; t++) begin
            if (t > 0) @(negedge clk);
            if (p_h_sync_o === 1'b1) hs_hi++;
            if (p_h_sync_o !== ((t >= 10 && t < 13) ? 1'b1 : 1'b0)) hs_bad++;
            if (p_de_o !== ((t < 8) ? 1'b1 : 1'b0)) de_bad++;
        end
        checks++; if (hs_hi != 3 || hs_bad != 0) begin failures++;
            $display("FAIL pol_hsync actual=%0d high %0d bad expected=3 high 0 bad", hs_hi, hs_bad); end
        checks++; if (de_bad != 0) begin failures++; $display("FAIL pol_de_nodelay actual=%0d bad expected=0", de_bad); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        bit found = 0;
        while (!found && n < 5000) begin
            @(negedge clk); n++;
            found = (s_h_cnt == 11'd40 && s_v_cnt < 11'd40);
        end
        checks++; if (!found) begin failures++; $display("FAIL arst_wait actual=timeout expected=h_cnt 40"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({s_h_cnt, s_v_cnt, d_h_cnt, d_v_cnt} !== 44'd0) begin failures++;
            $display("FAIL arst_cnt actual=%h expected=0", {s_h_cnt, s_v_cnt, d_h_cnt, d_v_cnt}); end
        checks++; if ({s_fetch_en, s_fetch_x, s_fetch_y, s_line_start, s_frame_start} !== 25'd0) begin failures++;
            $display("FAIL arst_fetch actual=%h expected=0", {s_fetch_en, s_fetch_x, s_fetch_y, s_line_start, s_frame_start}); end
        checks++; if ({s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o, p_h_sync_o} !== 5'b01100) begin failures++;
            $display("FAIL arst_pix actual=%b expected=01100", {s_de_o, s_h_sync_o, s_v_sync_o, s_vblank_o, p_h_sync_o}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({s_h_cnt, s_line_start, s_frame_start, s_de_o} !== 14'd0) begin failures++;
            $display("FAIL arst_no_partial actual=%h expected=0", {s_h_cnt, s_line_start, s_frame_start, s_de_o}); end
        @(negedge clk);
        checks++; if ({s_frame_start, s_h_cnt} !== {1'b1, 11'd1}) begin failures++;
            $display("FAIL arst_restart actual=%h expected=%h", {s_frame_start, s_h_cnt}, {1'b1, 11'd1}); end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_frame();
        test_scale();
        test_enable();
        test_polarity();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
REQ-002 Parameters: V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-003 Parameters: CNT_W 11 counter/position width; HSYNC_POL 0 and VSYNC_POL 0 (asserted sync level, 0 = active low); PIPE_DLY 2 extra clocks from fetch outputs to pixel-side outputs (0..7).
REQ-004 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL fit in CNT_W bits.
REQ-005 Ports: clk in 1 pixel clock; rst_n in 1 reset, asynchronous, active-low.
REQ-006 Ports: en in 1 timing enable; cfg_wr in 1 config strobe; cfg_scale in 2 position scale (0 = 1x, 1 = 2x, 2 = 4x, 3 = reserved, treated as 2).
REQ-007 Ports: h_cnt out CNT_W; v_cnt out CNT_W raw counters.
REQ-008 Ports: fetch_en out 1; fetch_x out CNT_W; fetch_y out CNT_W scaled fetch position; line_start out 1; frame_start out 1.
REQ-009 Ports: de_o out 1 active video; h_sync_o out 1; v_sync_o out 1; vblank_o out 1.

Function
REQ-010 h_cnt SHALL count 0..H_TOTAL-1 each clk while en=1, wrapping to 0.
REQ-011 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0 on the same clock h_cnt wraps from H_TOTAL-1.
REQ-012 Horizontal regions by h_cnt: active [0,H_ACTIVE), FP [H_ACTIVE,H_ACTIVE+H_FP), sync [H_ACTIVE+H_FP,H_ACTIVE+H_FP+H_SYNC), BP remainder; vertical regions identically by v_cnt.
REQ-013 Stage-0 outputs (fetch_en, fetch_x, fetch_y, line_start, frame_start) SHALL be registered decodes of the counter values of the previous clock: 1 clk latency.
REQ-014 fetch_en SHALL be 1 when h_cnt and v_cnt are both in active regions.
REQ-015 fetch_x = h_cnt >> scale_act and fetch_y = v_cnt >> scale_act (zero-extended); both hold 0 when fetch_en = 0.
REQ-016 line_start SHALL pulse one clock for h_cnt = 0 on every line; frame_start SHALL pulse one clock for h_cnt = 0 and v_cnt = 0.
REQ-017 Pixel-side outputs (de_o, h_sync_o, v_sync_o, vblank_o) SHALL be decoded with stage-0 timing, then delayed a further PIPE_DLY clocks through a shift register; PIPE_DLY = 0 means coincident with fetch_en.
REQ-018 h_sync_o = HSYNC_POL during the horizontal sync region, else ~HSYNC_POL; v_sync_o likewise for vertical sync region with VSYNC_POL, for all h_cnt of those lines.
REQ-019 de_o SHALL equal delayed fetch_en; vblank_o SHALL be 1 while v_cnt >= V_ACTIVE, delayed.
REQ-020 cfg_wr = 1 SHALL latch cfg_scale into a pending register; scale_act SHALL load from pending only when counters are (0,0), so scale never changes mid-frame; a cfg_wr on that same clock takes effect at the next frame.
REQ-021 en = 0 SHALL synchronously clear h_cnt and v_cnt to 0 and hold them; stage-0 and pixel-side outputs then take their reset values after their normal latency; re-asserting en starts at (0,0) with frame_start pulsing 1 clk later.

Reset
REQ-022 rst_n = 0 SHALL asynchronously clear h_cnt, v_cnt, fetch_x, fetch_y, fetch_en, line_start, frame_start, de_o, vblank_o, scale_act, the pending scale and all delay stages to 0, and set h_sync_o = ~HSYNC_POL and v_sync_o = ~VSYNC_POL.
REQ-023 After rst_n deasserts with en = 1, the first clock edge SHALL hold counters at (0,0) and the second edge SHALL begin counting; reset mid-frame SHALL discard position with no partial pulses.

Verification
REQ-024 Defaults, en = 1, run 2 frames -> h period 800 clks, h_sync_o low 96 clks beginning 656 clks after line_start, v period 525 lines, v_sync_o low for lines 490-491, de_o high 640 clks per line on 480 lines.
REQ-025 Defaults, PIPE_DLY = 2 -> de_o rises exactly 2 clks after fetch_en, h_sync_o edges likewise 2 clks after their stage-0 decode.
REQ-026 cfg_wr with cfg_scale = 1 at v_cnt = 100 -> fetch_x/fetch_y unchanged for the rest of that frame; next frame fetch_x = 0,0,1,1,...,319 and fetch_y spans 0..239.
REQ-027 Deassert en at (h = 300, v = 200) for 10 clks, then reassert -> counters stay 0, de_o = 0 after pipeline drains, frame_start pulses 1 clk after the restart.
REQ-028 Assert rst_n = 0 asynchronously mid-line -> all outputs reach their reset values before the next clk edge; HSYNC_POL = 1 build -> h_sync_o = 0 in reset and high during the sync region.
